// File: rtl/mips_pipe_pkg.sv
// Shared field widths, control bit positions and helpers for the MIPS pipeline stages.
package mips_pipe_pkg;

    localparam int unsigned WB_W   = 2;
    localparam int unsigned M_W    = 2;
    localparam int unsigned EX_W   = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;
    localparam int unsigned M_MEMREAD   = 1;
    localparam int unsigned M_MEMWRITE  = 0;
    localparam int unsigned EX_REGDST   = 3;
    localparam int unsigned EX_ALUSRC   = 0;

    localparam int unsigned      CTRL_NOP = 0;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // True when the WB write lands on the register being read in ID this cycle.
    function automatic logic wb_hit(input logic             we,
                                    input logic [REG_W-1:0] wreg,
                                    input logic [REG_W-1:0] rreg);
        return we && (wreg != REG_ZERO) && (wreg == rreg);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/WB inputs and EX-side outputs of the ID/EX stage; master drives ID/WB, slave is the stage.
interface id_ex_stage_if;
    import mips_pipe_pkg::*;

    logic              id_valid_i;
    logic [REG_W-1:0]  id_rs_i;
    logic [REG_W-1:0]  id_rt_i;
    logic [REG_W-1:0]  id_rd_i;
    logic [DATA_W-1:0] id_rs_data_i;
    logic [DATA_W-1:0] id_rt_data_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [WB_W-1:0]   id_wb_i;
    logic [M_W-1:0]    id_m_i;
    logic [EX_W-1:0]   id_ex_i;

    logic              wb_reg_write_i;
    logic [REG_W-1:0]  wb_write_reg_i;
    logic [DATA_W-1:0] wb_data_i;

    logic              ex_valid_o;
    logic [REG_W-1:0]  ex_rs_o;
    logic [REG_W-1:0]  ex_rt_o;
    logic [REG_W-1:0]  ex_rd_o;
    logic [DATA_W-1:0] ex_rs_data_o;
    logic [DATA_W-1:0] ex_rt_data_o;
    logic [DATA_W-1:0] ex_imm_o;
    logic [WB_W-1:0]   ex_wb_o;
    logic [M_W-1:0]    ex_m_o;
    logic [EX_W-1:0]   ex_ex_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_rs_data_i, id_rt_data_i, id_imm_i,
        output id_wb_i, id_m_i, id_ex_i, wb_reg_write_i, wb_write_reg_i, wb_data_i,
        input  ex_valid_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
        input  ex_wb_o, ex_m_o, ex_ex_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_rs_data_i, id_rt_data_i, id_imm_i,
        input  id_wb_i, id_m_i, id_ex_i, wb_reg_write_i, wb_write_reg_i, wb_data_i,
        output ex_valid_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
        output ex_wb_o, ex_m_o, ex_ex_o
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: a valid load in EX whose target is read by the ID instruction.
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             hazard_o
);

    logic w_src_match;

    always_comb begin
        w_src_match = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);
        hazard_o    = ex_valid_i && ex_mem_read_i && (ex_rt_i != REG_ZERO) && id_valid_i &&
                      w_src_match;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush/hold handling, WB bypass and bubble counter.
module id_ex_stage
    import mips_pipe_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic             flush_i,
    id_ex_stage_if.slave     bus,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic              r_ex_valid;
    logic [REG_W-1:0]  r_ex_rs;
    logic [REG_W-1:0]  r_ex_rt;
    logic [REG_W-1:0]  r_ex_rd;
    logic [DATA_W-1:0] r_ex_rs_data;
    logic [DATA_W-1:0] r_ex_rt_data;
    logic [DATA_W-1:0] r_ex_imm;
    logic [WB_W-1:0]   r_ex_wb;
    logic [M_W-1:0]    r_ex_m;
    logic [EX_W-1:0]   r_ex_ex;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_hazard;
    logic              w_stall;
    logic              w_bubble;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    load_use_detect u_load_use_detect (
        .ex_valid_i    (r_ex_valid),
        .ex_mem_read_i (r_ex_m[M_MEMREAD]),
        .ex_rt_i       (r_ex_rt),
        .id_valid_i    (bus.id_valid_i),
        .id_rs_i       (bus.id_rs_i),
        .id_rt_i       (bus.id_rt_i),
        .hazard_o      (w_hazard)
    );

    // A flush already squashes the ID instruction, so it overrides the stall.
    always_comb begin
        w_stall   = w_hazard && !hold_i && !flush_i;
        w_bubble  = flush_i || w_stall;
        w_rs_data = wb_hit(bus.wb_reg_write_i, bus.wb_write_reg_i, bus.id_rs_i) ?
                    bus.wb_data_i : bus.id_rs_data_i;
        w_rt_data = wb_hit(bus.wb_reg_write_i, bus.wb_write_reg_i, bus.id_rt_i) ?
                    bus.wb_data_i : bus.id_rt_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs      <= REG_ZERO;
            r_ex_rt      <= REG_ZERO;
            r_ex_rd      <= REG_ZERO;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
            r_ex_wb      <= WB_W'(CTRL_NOP);
            r_ex_m       <= M_W'(CTRL_NOP);
            r_ex_ex      <= EX_W'(CTRL_NOP);
        end else if (!hold_i) begin
            if (w_bubble) begin
                r_ex_valid   <= 1'b0;
                r_ex_rs      <= REG_ZERO;
                r_ex_rt      <= REG_ZERO;
                r_ex_rd      <= REG_ZERO;
                r_ex_rs_data <= '0;
                r_ex_rt_data <= '0;
                r_ex_imm     <= '0;
                r_ex_wb      <= WB_W'(CTRL_NOP);
                r_ex_m       <= M_W'(CTRL_NOP);
                r_ex_ex      <= EX_W'(CTRL_NOP);
            end else begin
                r_ex_valid   <= bus.id_valid_i;
                r_ex_rs      <= bus.id_rs_i;
                r_ex_rt      <= bus.id_rt_i;
                r_ex_rd      <= bus.id_rd_i;
                r_ex_rs_data <= w_rs_data;
                r_ex_rt_data <= w_rt_data;
                r_ex_imm     <= bus.id_imm_i;
                r_ex_wb      <= bus.id_wb_i;
                r_ex_m       <= bus.id_m_i;
                r_ex_ex      <= bus.id_ex_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bubble_cnt <= '0;
        end else if (w_stall && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign stall_o       = w_stall;
    assign pc_write_o    = !hold_i && !w_stall;
    assign if_id_write_o = !hold_i && !w_stall;
    assign bubble_cnt_o  = r_bubble_cnt;

    assign bus.ex_valid_o   = r_ex_valid;
    assign bus.ex_rs_o      = r_ex_rs;
    assign bus.ex_rt_o      = r_ex_rt;
    assign bus.ex_rd_o      = r_ex_rd;
    assign bus.ex_rs_data_o = r_ex_rs_data;
    assign bus.ex_rt_data_o = r_ex_rt_data;
    assign bus.ex_imm_o     = r_ex_imm;
    assign bus.ex_wb_o      = r_ex_wb;
    assign bus.ex_m_o       = r_ex_m;
    assign bus.ex_ex_o      = r_ex_ex;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural pipeline-slot model.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [3:0]  ex;
    } slot_t;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        stall;
    logic        pc_write;
    logic        if_id_write;
    logic [15:0] bubble_cnt;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .hold_i        (hold),
        .flush_i       (flush),
        .bus           (bus),
        .stall_o       (stall),
        .pc_write_o    (pc_write),
        .if_id_write_o (if_id_write),
        .bubble_cnt_o  (bubble_cnt)
    );

    slot_t dut_slot;
    assign dut_slot = {bus.ex_valid_o, bus.ex_rs_o, bus.ex_rt_o, bus.ex_rd_o, bus.ex_rs_data_o,
                       bus.ex_rt_data_o, bus.ex_imm_o, bus.ex_wb_o, bus.ex_m_o, bus.ex_ex_o};

    // Model: what instruction occupies the EX slot, and how many load-use bubbles so far.
    slot_t m_slot;
    int    m_cnt;
    int    n_cmp;
    int    n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_stall();
        logic uses_load;
        uses_load = m_slot.v && m_slot.m[1] && (m_slot.rt != 5'd0) && bus.id_valid_i &&
                    ((m_slot.rt == bus.id_rs_i) || (m_slot.rt == bus.id_rt_i));
        return uses_load && !hold && !flush;
    endfunction

    function automatic logic [31:0] fresh(input logic [4:0] r, input logic [31:0] stale);
        if (bus.wb_reg_write_i && (bus.wb_write_reg_i != 5'd0) && (bus.wb_write_reg_i == r))
            return bus.wb_data_i;
        return stale;
    endfunction

    task automatic tick();
        slot_t nxt;
        logic  st;
        st = exp_stall();
        if (hold) begin
            nxt = m_slot;
        end else if (flush || st) begin
            nxt = '0;
        end else begin
            nxt = '{v: bus.id_valid_i, rs: bus.id_rs_i, rt: bus.id_rt_i, rd: bus.id_rd_i,
                    rsd: fresh(bus.id_rs_i, bus.id_rs_data_i),
                    rtd: fresh(bus.id_rt_i, bus.id_rt_data_i),
                    imm: bus.id_imm_i, wb: bus.id_wb_i, m: bus.id_m_i, ex: bus.id_ex_i};
        end
        if (st && m_cnt < 65535) m_cnt++;
        @(posedge clk);
        m_slot = nxt;
        @(negedge clk);
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [1:0] wb, input logic [1:0] m,
                            input logic [3:0] ex);
        bus.id_valid_i   = v;
        bus.id_rs_i      = rs;
        bus.id_rt_i      = rt;
        bus.id_rd_i      = rd;
        bus.id_rs_data_i = $urandom;
        bus.id_rt_data_i = $urandom;
        bus.id_imm_i     = $urandom;
        bus.id_wb_i      = wb;
        bus.id_m_i       = m;
        bus.id_ex_i      = ex;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        bus.wb_reg_write_i = we;
        bus.wb_write_reg_i = r;
        bus.wb_data_i      = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        m_slot = '0;
        m_cnt  = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        hold  = 1'b0;
        flush = 1'b0;
        rst   = 1'b0;
        drive_id(1'b1, 5'd2, 5'd3, 5'd4, 2'b10, 2'b00, 4'b1100);
        drive_wb(1'b0, 5'd0, 32'h0);
        m_slot = '0;
        m_cnt  = 0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (dut_slot !== slot_t'(0)) begin
            n_bad++;
            $display("FAIL reset_ex got=%h exp=0", dut_slot);
        end
        n_cmp++;
        if ({stall, pc_write, if_id_write} !== 3'b011) begin
            n_bad++;
            $display("FAIL reset_ctl got=%b exp=011", {stall, pc_write, if_id_write});
        end
        n_cmp++;
        if (bubble_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt);
        end
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 5'd3, 5'd2, 5'd0, 2'b11, 2'b10, 4'b0011);
        tick();
        n_cmp++;
        if (dut_slot !== m_slot) begin
            n_bad++;
            $display("FAIL lu_load got=%h exp=%h", dut_slot, m_slot);
        end
        drive_id(1'b1, 5'd2, 5'd4, 5'd6, 2'b10, 2'b00, 4'b1100);
        #1;
        n_cmp++;
        if ({stall, pc_write, if_id_write} !== 3'b100) begin
            n_bad++;
            $display("FAIL lu_stall got=%b exp=100", {stall, pc_write, if_id_write});
        end
        tick();
        n_cmp++;
        if ({bus.ex_valid_o, bus.ex_wb_o, bubble_cnt} !== {1'b0, 2'b00, 16'd1}) begin
            n_bad++;
            $display("FAIL lu_bubble got=%b/%b/%0d exp=0/00/1", bus.ex_valid_o, bus.ex_wb_o,
                     bubble_cnt);
        end
        n_cmp++;
        if ({stall, pc_write} !== 2'b01) begin
            n_bad++;
            $display("FAIL lu_release got=%b exp=01", {stall, pc_write});
        end
        tick();
        n_cmp++;
        if (dut_slot !== m_slot || bus.ex_rs_o !== 5'd2 || bus.ex_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL lu_enter got=%h exp=%h", dut_slot, m_slot);
        end
    endtask

    task automatic test_no_hazard();
        drive_id(1'b1, 5'd3, 5'd0, 5'd0, 2'b11, 2'b10, 4'b0011);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd6, 2'b10, 2'b00, 4'b1100);
        #1;
        n_cmp++;
        if ({stall, pc_write} !== 2'b01) begin
            n_bad++;
            $display("FAIL nh_rt0 got=%b exp=01", {stall, pc_write});
        end
        drive_id(1'b1, 5'd3, 5'd2, 5'd0, 2'b11, 2'b10, 4'b0011);
        tick();
        drive_id(1'b1, 5'd7, 5'd9, 5'd6, 2'b10, 2'b00, 4'b1100);
        #1;
        n_cmp++;
        if ({stall, pc_write} !== 2'b01) begin
            n_bad++;
            $display("FAIL nh_diff got=%b exp=01", {stall, pc_write});
        end
        tick();
        n_cmp++;
        if (dut_slot !== m_slot || bubble_cnt !== 16'(m_cnt)) begin
            n_bad++;
            $display("FAIL nh_adv got=%h/%0d exp=%h/%0d", dut_slot, bubble_cnt, m_slot, m_cnt);
        end
    endtask

    task automatic test_flush_hazard();
        drive_id(1'b1, 5'd3, 5'd2, 5'd0, 2'b11, 2'b10, 4'b0011);
        tick();
        drive_id(1'b1, 5'd2, 5'd2, 5'd6, 2'b10, 2'b00, 4'b1100);
        flush = 1'b1;
        #1;
        n_cmp++;
        if ({stall, pc_write, if_id_write} !== 3'b011) begin
            n_bad++;
            $display("FAIL fl_ctl got=%b exp=011", {stall, pc_write, if_id_write});
        end
        tick();
        flush = 1'b0;
        n_cmp++;
        if (dut_slot !== slot_t'(0) || bubble_cnt !== 16'(m_cnt)) begin
            n_bad++;
            $display("FAIL fl_squash got=%h/%0d exp=0/%0d", dut_slot, bubble_cnt, m_cnt);
        end
    endtask

    task automatic test_hold();
        slot_t saved;
        drive_id(1'b1, 5'd3, 5'd2, 5'd0, 2'b11, 2'b10, 4'b0011);
        tick();
        saved = m_slot;
        hold  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 5'd2, 5'($urandom_range(31, 0)), 5'd1, 2'b10, 2'b00, 4'b0000);
            flush = 1'($urandom_range(1, 0));
            #1;
            n_cmp++;
            if ({stall, pc_write, if_id_write} !== 3'b000) begin
                n_bad++;
                $display("FAIL hold_ctl got=%b exp=000", {stall, pc_write, if_id_write});
            end
            tick();
            n_cmp++;
            if (dut_slot !== saved || bubble_cnt !== 16'(m_cnt)) begin
                n_bad++;
                $display("FAIL hold_keep got=%h exp=%h", dut_slot, saved);
            end
        end
        hold  = 1'b0;
        flush = 1'b0;
        drive_id(1'b1, 5'd8, 5'd9, 5'd10, 2'b10, 2'b00, 4'b1100);
        tick();
        n_cmp++;
        if (dut_slot !== m_slot || bus.ex_rs_o !== 5'd8) begin
            n_bad++;
            $display("FAIL hold_release got=%h exp=%h", dut_slot, m_slot);
        end
    endtask

    task automatic test_wb_bypass();
        drive_id(1'b1, 5'd5, 5'd6, 5'd7, 2'b10, 2'b00, 4'b1100);
        bus.id_rs_data_i = 32'h1;
        drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        n_cmp++;
        if (bus.ex_rs_data_o !== 32'hDEADBEEF || dut_slot !== m_slot) begin
            n_bad++;
            $display("FAIL byp_rs got=%h exp=deadbeef", bus.ex_rs_data_o);
        end
        drive_id(1'b1, 5'd0, 5'd5, 5'd7, 2'b10, 2'b00, 4'b1100);
        bus.id_rs_data_i = 32'h1;
        bus.id_rt_data_i = 32'h2;
        drive_wb(1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        n_cmp++;
        if ({bus.ex_rs_data_o, bus.ex_rt_data_o} !== {32'h1, 32'h2}) begin
            n_bad++;
            $display("FAIL byp_zero got=%h/%h exp=1/2", bus.ex_rs_data_o, bus.ex_rt_data_o);
        end
        drive_wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_back_to_back();
        int stalls;
        int cnt0;
        stalls = 0;
        cnt0   = m_cnt;
        drive_id(1'b1, 5'd8, 5'd1, 5'd0, 2'b11, 2'b10, 4'b0011);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) drive_id(1'b1, 5'd9, 5'd2, 5'd0, 2'b11, 2'b10, 4'b0011);
            if (i == 2) drive_id(1'b1, 5'd1, 5'd2, 5'd3, 2'b10, 2'b00, 4'b1100);
            if (i == 4) drive_id(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 4'b0000);
            #1;
            if (stall === 1'b1) stalls++;
            tick();
        end
        n_cmp++;
        if (stalls != 1 || bubble_cnt !== 16'(cnt0 + 1)) begin
            n_bad++;
            $display("FAIL b2b_stalls got=%0d/%0d exp=1/%0d", stalls, bubble_cnt, cnt0 + 1);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive_id(1'b1, 5'd3, 5'd2, 5'd0, 2'b11, 2'b10, 4'b0011);
        tick();
        drive_id(1'b1, 5'd2, 5'd4, 5'd6, 2'b10, 2'b00, 4'b1100);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (dut_slot !== slot_t'(0) || {stall, pc_write} !== 2'b01 || bubble_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_mid got=%h/%b/%0d exp=0/01/0", dut_slot, {stall, pc_write},
                     bubble_cnt);
        end
        m_slot = '0;
        m_cnt  = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        int bad_seq;
        int bad_cmb;
        bad_seq = 0;
        bad_cmb = 0;
        for (int i = 0; i < 2000; i++) begin
            drive_id(1'($urandom_range(3, 0) != 0), 5'($urandom_range(3, 0)),
                     5'($urandom_range(3, 0)), 5'($urandom_range(31, 0)),
                     2'($urandom), 2'($urandom), 4'($urandom));
            drive_wb(1'($urandom), 5'($urandom_range(3, 0)), $urandom);
            hold  = ($urandom_range(9, 0) == 0);
            flush = ($urandom_range(9, 0) == 0);
            #1;
            n_cmp++;
            if ({stall, pc_write, if_id_write} !==
                {exp_stall(), !hold && !exp_stall(), !hold && !exp_stall()}) begin
                n_bad++;
                bad_cmb++;
                if (bad_cmb < 5)
                    $display("FAIL rnd_ctl cyc=%0d got=%b stall_exp=%b hold=%b", i,
                             {stall, pc_write, if_id_write}, exp_stall(), hold);
            end
            tick();
            n_cmp++;
            if (dut_slot !== m_slot || bubble_cnt !== 16'(m_cnt)) begin
                n_bad++;
                bad_seq++;
                if (bad_seq < 5)
                    $display("FAIL rnd_state cyc=%0d got=%h/%0d exp=%h/%0d", i, dut_slot,
                             bubble_cnt, m_slot, m_cnt);
            end
        end
        hold  = 1'b0;
        flush = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            drive_id(1'b1, 5'd3, 5'd1, 5'd0, 2'b11, 2'b10, 4'b0011);
            tick();
            drive_id(1'b1, 5'd1, 5'd4, 5'd6, 2'b10, 2'b00, 4'b1100);
            tick();
            if (i == 65533) begin
                n_cmp++;
                if (bubble_cnt !== 16'hFFFE) begin
                    n_bad++;
                    $display("FAIL sat_pre got=%h exp=fffe", bubble_cnt);
                end
            end
        end
        n_cmp++;
        if (bubble_cnt !== 16'hFFFF || m_cnt != 65535) begin
            n_bad++;
            $display("FAIL sat_hold got=%h exp=ffff", bubble_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush_hazard();
        test_hold();
        test_wb_bypass();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
